ad9826_serial_responder: RTL and testbench
==========================================

Name: ad9826_serial_responder

Overview:
- Synthesizable responder (slave) end of the AD9826 3-wire serial port.
- Decodes 16-bit frames framed by active-low sload, clocked by sclk (SPI mode 0, MSB first), into an 8 x 9-bit register file.
- Drives read data back on the shared sdata line.
- Used for FPGA loopback bring-up of the serial controller and as the sensor-AFE model in system benches. Runs entirely in the fast system clock domain by oversampling the serial pins.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sclk_i, sload_i and sdata_i (minimum 2).
- REG_RESET, 72'h0, packed reset image of the register file; register n occupies bits [9n+8:9n].

Ports:
- clk  in  1  system clock; must be at least 8x sclk frequency.
- rst  in  1  reset; synchronous, active-high.
- sclk_i  in  1  serial clock from initiator; idle low.
- sload_i  in  1  frame select, active low.
- sdata_i  in  1  serial data from initiator.
- sdata_o  out  1  serial read data to initiator.
- sdata_oe_o  out  1  1 = responder drives sdata; combine with sdata_o into a tristate at top level.
- local_addr_i  in  3  local (fabric-side) register write address.
- local_data_i  in  9  local write data.
- local_wr_i  in  1  local write strobe.
- regs_o  out  72  register file, same packing as REG_RESET.
- wr_strobe_o  out  1  one-cycle pulse when a serial write commits.
- wr_addr_o  out  3  address of the last serial write; valid with wr_strobe_o.
- rd_strobe_o  out  1  one-cycle pulse when a serial read frame completes.
- frame_err_o  out  1  one-cycle pulse when a frame is aborted (bit count is not 16).

Behaviour:
- Frame format, MSB first: bit15 R/nW (1 = read), bits14:12 address, bits11:9 don't care, bits8:0 data.
- Input synchronization:
  - All three serial inputs pass through SYNC_STAGES flops plus one edge-detect register.
  - Pin-to-internal-edge latency is SYNC_STAGES+1 clk.
- Edge handling:
  - sclk rising edge: sample sdata into the shift register and increment bit_cnt (5 bits).
  - sclk falling edge: update sdata_o.
- States: IDLE, CMD, DATA, OVERRUN.
  - IDLE: wait for a sload falling edge. On it: bit_cnt=0, go to CMD. A sload already low out of reset does not start a frame.
  - CMD: after the 4th rising edge, latch R/nW and address. After the 7th rising edge, go to DATA.
  - DATA, read frame: on the falling edge following the 7th rising edge, set sdata_oe_o=1 and drive reg[addr][8]. Each later falling edge shifts out the next bit, down to [0]. After the 16th rising edge, go to OVERRUN, keeping sdata_oe_o=1 until the sload rising edge.
  - DATA, write frame: bits 8:0 shift in; the register is not written until the frame closes.
  - OVERRUN: any further sclk rising edge marks the frame bad.
- sload rising edge (any state):
  - Write frame with exactly 16 edges: commit data to reg[addr]; wr_strobe_o=1 and wr_addr_o=addr in the same cycle that regs_o updates.
  - Read frame with exactly 16 edges: rd_strobe_o=1.
  - Any other bit count (including 17 or more): frame_err_o=1, no write.
  - All cases: sdata_oe_o=0 on the next cycle, return to IDLE.
- Simultaneous events:
  - An sclk edge and a sload rising edge detected in the same cycle: the sclk edge is ignored.
  - A serial commit and local_wr_i in the same cycle: the serial write wins and the local write is dropped.
  - A local write to the address currently being read mid-frame does not alter bits already shifted out; later bits come from the new value.
- Local writes: one-cycle latency to regs_o; no strobes.
- Reset values: regs_o=REG_RESET; sdata_o=0, sdata_oe_o=0, all strobes 0, wr_addr_o=0; state IDLE.
- Reset mid-frame aborts the frame with no write and no frame_err_o. The remainder of that frame is ignored until a fresh sload falling edge.
- Timing requirement: sclk high and low phases are each at least 4 clk, and sload setup/hold to sclk is at least 4 clk.

Decomposition:
- Shared package ad9826_pkg holds:
  - AD9826_FRAME_BITS=16, AD9826_ADDR_W=3, AD9826_DATA_W=9, AD9826_RW_BIT=15, AD9826_CMD_BITS=7.
  - Address constants (CONFIG=0, MUX=1, PGA_R/G/B=2..4, OFFSET_R/G/B=5..7).
  - Responder state enum.
- One natural sub-module, sync_edge_detect: a parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated per input pin. The initiator-side controller can reuse it.

Test Plan:
- Serial write addr 3, data 9'h1A5, sclk = clk/20: after the sload rising edge, regs_o[35:27]=9'h1A5; wr_strobe_o pulses once with wr_addr_o=3; no other register changes.
- Local write addr 6 = 9'h0F3, then serial read addr 6: sdata_oe_o rises after the 7th sclk rising edge; the 9 sampled bits equal 9'h0F3; rd_strobe_o pulses; sdata_oe_o=0 within SYNC_STAGES+2 clk of sload high.
- Write frame aborted after 10 edges, and a write frame of 17 edges: frame_err_o pulses for each; the target register keeps its prior value; no wr_strobe_o.
- rst asserted during bit 12 of a write to addr 1: regs_o returns to REG_RESET; frame_err_o and wr_strobe_o stay 0; the next complete frame writes correctly.
- serial commit to addr 2 coincident with local_wr_i to addr 2 (9'h111): final value is the serial data; wr_strobe_o=1.
- Back-to-back frames with a minimum 4-clk sload high gap, using the initiator controller at divider 50 in loopback: write then read of all 8 addresses round-trips every value.

Source files
------------

// File: rtl/ad9826_pkg.sv
// Shared constants, register map and responder state encoding for the AD9826
// 3-wire serial port (responder and initiator sides).
package ad9826_pkg;

    localparam int AD9826_FRAME_BITS = 16;
    localparam int AD9826_ADDR_W     = 3;
    localparam int AD9826_DATA_W     = 9;
    localparam int AD9826_RW_BIT     = 15;
    localparam int AD9826_CMD_BITS   = 7;
    localparam int AD9826_NUM_REGS   = 8;
    localparam int AD9826_REGS_W     = AD9826_NUM_REGS * AD9826_DATA_W;
    // R/nW plus the three address bits have all arrived after this many edges.
    localparam int AD9826_HDR_BITS   = 4;

    localparam logic [AD9826_ADDR_W-1:0] AD9826_ADDR_CONFIG   = 3'd0;
    localparam logic [AD9826_ADDR_W-1:0] AD9826_ADDR_MUX      = 3'd1;
    localparam logic [AD9826_ADDR_W-1:0] AD9826_ADDR_PGA_R    = 3'd2;
    localparam logic [AD9826_ADDR_W-1:0] AD9826_ADDR_PGA_G    = 3'd3;
    localparam logic [AD9826_ADDR_W-1:0] AD9826_ADDR_PGA_B    = 3'd4;
    localparam logic [AD9826_ADDR_W-1:0] AD9826_ADDR_OFFSET_R = 3'd5;
    localparam logic [AD9826_ADDR_W-1:0] AD9826_ADDR_OFFSET_G = 3'd6;
    localparam logic [AD9826_ADDR_W-1:0] AD9826_ADDR_OFFSET_B = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA    = 2'd2,
        ST_OVERRUN = 2'd3
    } resp_state_e;

endpackage

// File: rtl/ad9826_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from one extra history register.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Clearing to 0 means a pin already low at reset release never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/ad9826_serial_responder.sv
// Responder end of the AD9826 3-wire port: oversamples sclk/sload/sdata in the
// system clock domain, decodes 16-bit frames and serves an 8 x 9-bit register file.
module ad9826_serial_responder
    import ad9826_pkg::*;
#(
    parameter int                       SYNC_STAGES = 2,
    parameter logic [AD9826_REGS_W-1:0] REG_RESET   = 72'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk_i,
    input  logic                     sload_i,
    input  logic                     sdata_i,
    output logic                     sdata_o,
    output logic                     sdata_oe_o,
    input  logic [AD9826_ADDR_W-1:0] local_addr_i,
    input  logic [AD9826_DATA_W-1:0] local_data_i,
    input  logic                     local_wr_i,
    output logic [AD9826_REGS_W-1:0] regs_o,
    output logic                     wr_strobe_o,
    output logic [AD9826_ADDR_W-1:0] wr_addr_o,
    output logic                     rd_strobe_o,
    output logic                     frame_err_o
);

    localparam logic [4:0] HDR_CNT   = 5'(AD9826_HDR_BITS);
    localparam logic [4:0] CMD_CNT   = 5'(AD9826_CMD_BITS);
    localparam logic [4:0] FRAME_CNT = 5'(AD9826_FRAME_BITS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sload_lvl, sload_rise, sload_fall;
    logic sdata_lvl, sdata_rise, sdata_fall;
    logic edges_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk_i),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sload (
        .clk(clk), .rst(rst), .din(sload_i),
        .level(sload_lvl), .rise(sload_rise), .fall(sload_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk(clk), .rst(rst), .din(sdata_i),
        .level(sdata_lvl), .rise(sdata_rise), .fall(sdata_fall)
    );

    assign edges_unused = ^{sclk_lvl, sload_lvl, sdata_rise, sdata_fall};

    resp_state_e              state_q, state_d;
    logic [4:0]               cnt_q, cnt_d, cnt_inc;
    logic [AD9826_DATA_W-1:0] shift_q, shift_d;
    logic                     rw_q, rw_d;
    logic [AD9826_ADDR_W-1:0] addr_q, addr_d;
    logic                     sdo_d, oe_d;
    logic                     wr_stb_d, rd_stb_d, err_d;
    logic [AD9826_ADDR_W-1:0] wr_addr_d;
    logic                     commit;
    logic [3:0]               bit_idx;
    logic [AD9826_DATA_W-1:0] regs_q [AD9826_NUM_REGS];

    assign cnt_inc = cnt_q + 5'd1;
    // Falling edge after rising edge n carries data bit 15-n (n = 7..15 gives 8..0).
    assign bit_idx = 4'(AD9826_FRAME_BITS - 1) - cnt_q[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            sdata_o     <= 1'b0;
            sdata_oe_o  <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            rd_strobe_o <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            sdata_o     <= sdo_d;
            sdata_oe_o  <= oe_d;
            wr_strobe_o <= wr_stb_d;
            wr_addr_o   <= wr_addr_d;
            rd_strobe_o <= rd_stb_d;
            frame_err_o <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        sdo_d     = sdata_o;
        oe_d      = sdata_oe_o;
        wr_addr_d = wr_addr_o;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        err_d     = 1'b0;
        commit    = 1'b0;
        // Frame close outranks any sclk edge seen in the same cycle.
        if (sload_rise && (state_q != ST_IDLE)) begin
            if (cnt_q == FRAME_CNT) begin
                if (rw_q) begin
                    rd_stb_d = 1'b1;
                end else begin
                    commit    = 1'b1;
                    wr_stb_d  = 1'b1;
                    wr_addr_d = addr_q;
                end
            end else begin
                err_d = 1'b1;
            end
            oe_d    = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sload_fall) begin
                        cnt_d   = '0;
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[AD9826_DATA_W-2:0], sdata_lvl};
                        cnt_d   = cnt_inc;
                        if (cnt_inc == HDR_CNT) begin
                            rw_d   = shift_q[2];
                            addr_d = {shift_q[1:0], sdata_lvl};
                        end
                        if (cnt_inc == CMD_CNT) begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[AD9826_DATA_W-2:0], sdata_lvl};
                        cnt_d   = cnt_inc;
                        if (cnt_inc == FRAME_CNT) begin
                            state_d = ST_OVERRUN;
                        end
                    end else if (sclk_fall && rw_q) begin
                        oe_d  = 1'b1;
                        sdo_d = regs_q[addr_q][bit_idx];
                    end
                end
                ST_OVERRUN: begin
                    if (sclk_rise && (cnt_q != 5'h1f)) begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Serial commit takes priority; a coincident local write is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < AD9826_NUM_REGS; n++) begin
                regs_q[n] <= REG_RESET[n*AD9826_DATA_W +: AD9826_DATA_W];
            end
        end else if (commit) begin
            regs_q[addr_q] <= shift_q;
        end else if (local_wr_i) begin
            regs_q[local_addr_i] <= local_data_i;
        end
    end

    always_comb begin
        for (int n = 0; n < AD9826_NUM_REGS; n++) begin
            regs_o[n*AD9826_DATA_W +: AD9826_DATA_W] = regs_q[n];
        end
    end

endmodule

// File: tb/tb_ad9826_serial_responder.sv
// Directed bench for the AD9826 serial responder: bit-banged initiator frames,
// hand-computed register images and strobe counts.
module tb_ad9826_serial_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        sload;
    logic        sdata_in;
    logic        sdata_out;
    logic        sdata_oe;
    logic [2:0]  local_addr;
    logic [8:0]  local_data;
    logic        local_wr;
    logic [71:0] regs;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic        rd_strobe;
    logic        frame_err;

    int vectors     = 0;
    int miscompares = 0;

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          err_cnt = 0;
    logic [2:0]  last_wr_addr = '0;
    logic [8:0]  last_wr_data = '0;
    logic [8:0]  exp_regs [8];
    logic [8:0]  tbl [8];

    ad9826_serial_responder #(
        .SYNC_STAGES(2),
        .REG_RESET  (72'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk_i      (sclk),
        .sload_i     (sload),
        .sdata_i     (sdata_in),
        .sdata_o     (sdata_out),
        .sdata_oe_o  (sdata_oe),
        .local_addr_i(local_addr),
        .local_data_i(local_data),
        .local_wr_i  (local_wr),
        .regs_o      (regs),
        .wr_strobe_o (wr_strobe),
        .wr_addr_o   (wr_addr),
        .rd_strobe_o (rd_strobe),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge; write data captured with the strobe.
    always @(negedge clk) begin
        if (wr_strobe) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = wr_addr;
            last_wr_data = regs[wr_addr*9 +: 9];
        end
        if (rd_strobe) rd_cnt = rd_cnt + 1;
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pack_exp();
        logic [71:0] p;
        for (int n = 0; n < 8; n++) p[n*9 +: 9] = exp_regs[n];
        return p;
    endfunction

    function automatic logic [15:0] mk_word(input logic rw, input logic [2:0] a, input logic [8:0] d);
        return {rw, a, 3'b000, d};
    endfunction

    // Mode-0 initiator: data set while sclk low, read data sampled just before each rise.
    task automatic send_frame(input logic [15:0] word, input int nbits, input int half,
                              input int rst_at, input bit coincide,
                              output logic [8:0] rdata, output int oe_first);
        rdata    = '0;
        oe_first = -1;
        sload    = 1'b0;
        wait_clks(half);
        for (int i = 0; i < nbits; i++) begin
            sdata_in = (i < 16) ? word[15-i] : 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                wait_clks(2);
                rst = 1'b0;
            end
            wait_clks(half);
            if (sdata_oe && oe_first < 0) oe_first = i;
            if (i >= 7 && i <= 15) rdata[15-i] = sdata_out;
            sclk = 1'b1;
            wait_clks(half);
            sclk = 1'b0;
        end
        wait_clks(half);
        sload = 1'b1;
        if (coincide) begin
            wait_clks(2);
            local_addr = 3'd2;
            local_data = 9'h111;
            local_wr   = 1'b1;
            wait_clks(1);
            local_wr   = 1'b0;
            wait_clks(1);
        end else begin
            wait_clks(4);
        end
    endtask

    initial begin
        logic [8:0] rd;
        int         oe_first;
        int         wr0, rd0, err0;

        rst        = 1'b1;
        sclk       = 1'b0;
        sload      = 1'b1;
        sdata_in   = 1'b0;
        local_addr = '0;
        local_data = '0;
        local_wr   = 1'b0;
        for (int n = 0; n < 8; n++) exp_regs[n] = 9'h000;
        tbl[0] = 9'h101; tbl[1] = 9'h0A2; tbl[2] = 9'h153; tbl[3] = 9'h0E4;
        tbl[4] = 9'h1F5; tbl[5] = 9'h016; tbl[6] = 9'h127; tbl[7] = 9'h0B8;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(6);

        // Reset state; the sload high seen after reset must not count as a frame
        check("reset_regs",     regs, 72'h0);
        check("reset_oe",       sdata_oe, 1'b0);
        check("reset_sdata",    sdata_out, 1'b0);
        check("reset_wr_addr",  wr_addr, 3'd0);
        check("reset_strobes",  wr_cnt + rd_cnt + err_cnt, 0);

        // Serial write addr 3 = 1A5 at sclk = clk/20
        wr0 = wr_cnt; err0 = err_cnt;
        send_frame(mk_word(1'b0, 3'd3, 9'h1A5), 16, 10, -1, 1'b0, rd, oe_first);
        exp_regs[3] = 9'h1A5;
        check("wr3_regs",      regs, pack_exp());
        check("wr3_strobes",   wr_cnt - wr0, 1);
        check("wr3_addr",      last_wr_addr, 3'd3);
        check("wr3_same_cyc",  last_wr_data, 9'h1A5);
        check("wr3_no_err",    err_cnt - err0, 0);

        // Local write addr 6, then serial read of it
        local_addr = 3'd6;
        local_data = 9'h0F3;
        local_wr   = 1'b1;
        wait_clks(1);
        local_wr   = 1'b0;
        exp_regs[6] = 9'h0F3;
        check("local_wr6", regs, pack_exp());
        wr0 = wr_cnt; rd0 = rd_cnt;
        send_frame(mk_word(1'b1, 3'd6, 9'h000), 16, 10, -1, 1'b0, rd, oe_first);
        check("rd6_data",     rd, 9'h0F3);
        check("rd6_oe_edge",  oe_first, 7);
        check("rd6_strobe",   rd_cnt - rd0, 1);
        check("rd6_oe_off",   sdata_oe, 1'b0);
        check("rd6_no_wr",    wr_cnt - wr0, 0);

        // Short (10 edge) and long (17 edge) write frames are rejected
        wr0 = wr_cnt; err0 = err_cnt;
        send_frame(mk_word(1'b0, 3'd3, 9'h055), 10, 10, -1, 1'b0, rd, oe_first);
        check("short_err",  err_cnt - err0, 1);
        send_frame(mk_word(1'b0, 3'd3, 9'h0AA), 17, 10, -1, 1'b0, rd, oe_first);
        check("long_err",   err_cnt - err0, 2);
        check("bad_regs",   regs, pack_exp());
        check("bad_no_wr",  wr_cnt - wr0, 0);

        // Reset during bit 12 of a write to addr 1, then a clean write
        wr0 = wr_cnt; err0 = err_cnt;
        send_frame(mk_word(1'b0, 3'd1, 9'h1C3), 16, 10, 11, 1'b0, rd, oe_first);
        for (int n = 0; n < 8; n++) exp_regs[n] = 9'h000;
        check("rst_regs",    regs, pack_exp());
        check("rst_no_err",  err_cnt - err0, 0);
        check("rst_no_wr",   wr_cnt - wr0, 0);
        send_frame(mk_word(1'b0, 3'd1, 9'h1C3), 16, 10, -1, 1'b0, rd, oe_first);
        exp_regs[1] = 9'h1C3;
        check("post_rst_regs", regs, pack_exp());
        check("post_rst_wr",   wr_cnt - wr0, 1);

        // Serial commit to addr 2 coincides with a local write of 111 to addr 2
        wr0 = wr_cnt;
        send_frame(mk_word(1'b0, 3'd2, 9'h0C7), 16, 10, -1, 1'b1, rd, oe_first);
        exp_regs[2] = 9'h0C7;
        check("coll_regs",  regs, pack_exp());
        check("coll_wr",    wr_cnt - wr0, 1);
        check("coll_addr",  last_wr_addr, 3'd2);

        // Back-to-back round trip of every address at divider 50, 4-clk gaps
        wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt;
        for (int a = 0; a < 8; a++) begin
            send_frame(mk_word(1'b0, 3'(a), tbl[a]), 16, 25, -1, 1'b0, rd, oe_first);
            exp_regs[a] = tbl[a];
        end
        for (int a = 0; a < 8; a++) begin
            send_frame(mk_word(1'b1, 3'(a), 9'h000), 16, 25, -1, 1'b0, rd, oe_first);
            check($sformatf("rt_rd%0d", a), rd, tbl[a]);
        end
        check("rt_regs",    regs, pack_exp());
        check("rt_counts",  {wr_cnt - wr0, rd_cnt - rd0, err_cnt - err0}, {32'd8, 32'd8, 32'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
